// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_ZERO          = 0;
    localparam int LINK_REG_DEFAULT  = 31;
    localparam int DATA_W_DEFAULT    = 64;
    localparam int NUM_REGS_DEFAULT  = 32;

    // Ceiling log2 for sizing address fields; returns 0 for an input of 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read addresses/data/busy, write port, allocate port.
// Latency: n/a (wiring only).
// Backpressure: none; every field is sampled or produced every cycle.
// Ports: master = ID-stage driver (addresses, write, alloc); slave = register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int NUM_RD   = 2
) ();

    localparam int AW = clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_link;
    logic                     alloc_en;
    logic [AW-1:0]            alloc_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_link, alloc_en, alloc_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_link, alloc_en, alloc_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: data + busy lookup with write-first bypass.
// Latency: 1 cycle from rd_addr to rd_data/rd_busy.
// Backpressure: none. Ports: rd_addr in, storage/scoreboard/qualified write in, rd_data/rd_busy out.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int AW       = clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic              wr_hit_en,   // write is real: wr_en set and target nonzero
    input  logic [AW-1:0]     wr_addr,     // effective (link-resolved) destination
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_addr == AW'(REG_ZERO)) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (wr_hit_en && (wr_addr == rd_addr)) begin
            // The writeback retires the producer, so the consumer sees fresh data and not-busy.
            rd_data <= wr_data;
            rd_busy <= 1'b0;
        end else begin
            rd_data <= regs[rd_addr];
            rd_busy <= busy[rd_addr];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with busy scoreboard and link write path.
// Latency: 1 cycle reads (write-first bypass), writes/allocs take effect at the next edge.
// Backpressure: none. Ports: clk, rst (sync, active-high), bus (regfile_mp_if.slave).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int NUM_RD     = 2,
    parameter int LINK_REG   = LINK_REG_DEFAULT,
    parameter int INIT_INDEX = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int            AW     = clog2(NUM_REGS);
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [AW-1:0]       ea;
    logic                wr_ok;
    logic                alloc_ok;

    // A link write ignores wr_addr; a resolved target of r0 (incl. LINK_REG=0) is dropped.
    assign ea       = bus.wr_link ? LINK_A : bus.wr_addr;
    assign wr_ok    = bus.wr_en && (ea != ZERO_A);
    assign alloc_ok = bus.alloc_en && (bus.alloc_addr != ZERO_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (INIT_INDEX != 0 && i != REG_ZERO) ? DATA_W'(i) : '0;
            end
        end else if (wr_ok) begin
            regs[ea] <= bus.wr_data;
        end
    end

    // Alloc is assigned after the writeback clear so a same-cycle new producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[ea] <= 1'b0;
            end
            if (alloc_ok) begin
                busy[bus.alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .AW       (AW)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .rd_addr   (bus.rd_addr[k*AW +: AW]),
            .regs      (regs),
            .busy      (busy),
            .wr_hit_en (wr_ok),
            .wr_addr   (ea),
            .wr_data   (bus.wr_data),
            .rd_data   (bus.rd_data[k*DATA_W +: DATA_W]),
            .rd_busy   (bus.rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two configurations (64b/32x2 INIT_INDEX=1, 32b/16x3 INIT_INDEX=0).
// Expected read results are computed from a reference model when inputs are driven,
// queued, and compared one edge later against the registered outputs.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) ifb ();

    regfile_mp #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .LINK_REG(31), .INIT_INDEX(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .LINK_REG(15), .INIT_INDEX(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    typedef struct {
        string       tag;
        bit          inst;
        int          port;
        logic [63:0] data;
        logic        busy;
    } exp_t;

    exp_t sbq[$];

    logic [63:0] ma_regs [32];
    logic        ma_busy [32];
    logic [31:0] mb_regs [16];
    logic        mb_busy [16];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] got_d;
        logic        got_b;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.inst == 1'b0) begin
                got_d = ifa.rd_data[e.port*64 +: 64];
                got_b = ifa.rd_busy[e.port];
            end else begin
                got_d = {32'h0, ifb.rd_data[e.port*32 +: 32]};
                got_b = ifb.rd_busy[e.port];
            end
            check({e.tag, "_data"}, got_d, e.data);
            check({e.tag, "_busy"}, 64'(got_b), 64'(e.busy));
        end
    endtask

    task automatic cyc_a(input string tag, input bit r, input int a0, input int a1,
                         input bit we, input int wa, input logic [63:0] wd, input bit lk,
                         input bit ae, input int aa);
        int   ad [2];
        int   ea;
        bit   hit;
        exp_t e;
        @(negedge clk);
        rst_a          = r;
        ifa.rd_addr    = {5'(a1), 5'(a0)};
        ifa.wr_en      = we;
        ifa.wr_addr    = 5'(wa);
        ifa.wr_data    = wd;
        ifa.wr_link    = lk;
        ifa.alloc_en   = ae;
        ifa.alloc_addr = 5'(aa);
        ad[0] = a0;
        ad[1] = a1;
        ea  = lk ? 31 : wa;
        hit = we && (ea != 0);
        for (int k = 0; k < 2; k++) begin
            e.tag  = $sformatf("%s_a%0d", tag, k);
            e.inst = 1'b0;
            e.port = k;
            if (r || ad[k] == 0) begin
                e.data = 64'h0;
                e.busy = 1'b0;
            end else if (hit && ea == ad[k]) begin
                e.data = wd;
                e.busy = 1'b0;
            end else begin
                e.data = ma_regs[ad[k]];
                e.busy = ma_busy[ad[k]];
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                ma_regs[i] = 64'(i);
                ma_busy[i] = 1'b0;
            end
        end else begin
            if (hit) begin
                ma_regs[ea] = wd;
                ma_busy[ea] = 1'b0;
            end
            if (ae && aa != 0) ma_busy[aa] = 1'b1;
        end
        #1;
        drain();
    endtask

    task automatic cyc_b(input string tag, input bit r, input int a0, input int a1, input int a2,
                         input bit we, input int wa, input logic [31:0] wd, input bit lk,
                         input bit ae, input int aa);
        int   ad [3];
        int   ea;
        bit   hit;
        exp_t e;
        @(negedge clk);
        rst_b          = r;
        ifb.rd_addr    = {4'(a2), 4'(a1), 4'(a0)};
        ifb.wr_en      = we;
        ifb.wr_addr    = 4'(wa);
        ifb.wr_data    = wd;
        ifb.wr_link    = lk;
        ifb.alloc_en   = ae;
        ifb.alloc_addr = 4'(aa);
        ad[0] = a0;
        ad[1] = a1;
        ad[2] = a2;
        ea  = lk ? 15 : wa;
        hit = we && (ea != 0);
        for (int k = 0; k < 3; k++) begin
            e.tag  = $sformatf("%s_b%0d", tag, k);
            e.inst = 1'b1;
            e.port = k;
            if (r || ad[k] == 0) begin
                e.data = 64'h0;
                e.busy = 1'b0;
            end else if (hit && ea == ad[k]) begin
                e.data = {32'h0, wd};
                e.busy = 1'b0;
            end else begin
                e.data = {32'h0, mb_regs[ad[k]]};
                e.busy = mb_busy[ad[k]];
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                mb_regs[i] = 32'h0;
                mb_busy[i] = 1'b0;
            end
        end else begin
            if (hit) begin
                mb_regs[ea] = wd;
                mb_busy[ea] = 1'b0;
            end
            if (ae && aa != 0) mb_busy[aa] = 1'b1;
        end
        #1;
        drain();
    endtask

    initial begin
        ifa.rd_addr = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.wr_link = 1'b0; ifa.alloc_en = 1'b0; ifa.alloc_addr = '0;
        ifb.rd_addr = '0; ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifb.wr_link = 1'b0; ifb.alloc_en = 1'b0; ifb.alloc_addr = '0;
        for (int i = 0; i < 32; i++) begin ma_regs[i] = '0; ma_busy[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin mb_regs[i] = '0; mb_busy[i] = 1'b0; end

        // 64-bit, 32 regs, 2 ports, INIT_INDEX=1
        cyc_a("rst",     1, 0, 0,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("rst2",    1, 5, 0,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("init_r5", 0, 5, 0,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("bypass",  0, 7, 6,  1, 7, 64'hDEAD_BEEF_0000_0001, 0,  0, 0);
        cyc_a("stable",  0, 7, 7,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("link",    0, 31, 3, 1, 3, 64'h1234, 1,  0, 0);
        cyc_a("link_rd", 0, 31, 3, 0, 0, 64'h0, 0,  0, 0);
        cyc_a("nolink",  0, 31, 3, 0, 3, 64'h5555, 1,  0, 0);
        cyc_a("wr_r0",   0, 0, 7,  1, 0, 64'hFF, 0,  0, 0);
        cyc_a("rd_r0",   0, 0, 0,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("alloc9",  0, 9, 9,  0, 0, 64'h0, 0,  1, 9);
        cyc_a("busy9",   0, 9, 8,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("wr9",     0, 9, 9,  1, 9, 64'hCAFE, 0,  0, 0);
        cyc_a("aw9",     0, 9, 0,  1, 9, 64'hBEEF, 0,  1, 9);
        cyc_a("aw9_rd",  0, 9, 9,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("alloc1",  0, 1, 9,  0, 0, 64'h0, 0,  1, 1);
        cyc_a("mrst",    1, 2, 9,  1, 2, 64'hAAAA, 0,  1, 5);
        cyc_a("post",    0, 2, 9,  0, 0, 64'h0, 0,  0, 0);
        cyc_a("post2",   0, 5, 1,  0, 0, 64'h0, 0,  0, 0);

        // 32-bit, 16 regs, 3 ports, INIT_INDEX=0, LINK_REG=15
        cyc_b("brst",    1, 0, 0, 0,    0, 0, 32'h0, 0,  0, 0);
        cyc_b("bw4",     0, 4, 4, 15,   1, 4, 32'h1111_2222, 0,  0, 0);
        cyc_b("blink",   0, 4, 4, 15,   1, 2, 32'hFFFF_FFFF, 1,  0, 0);
        cyc_b("brd",     0, 4, 4, 15,   0, 0, 32'h0, 0,  0, 0);
        cyc_b("balloc0", 0, 0, 4, 15,   0, 0, 32'h0, 0,  1, 0);
        cyc_b("bzero",   0, 0, 0, 2,    0, 0, 32'h0, 0,  0, 0);
        cyc_b("balloc4", 0, 4, 4, 4,    0, 0, 32'h0, 0,  1, 4);
        cyc_b("bbusy4",  0, 4, 0, 15,   0, 0, 32'h0, 0,  0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
